// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Bundles the command, ALU and response channels of alu_op_sequencer.
//   cmd_*      : command push channel (valid/ready, opcode, operands, tag)
//   alu_*      : operands/opcode driven to an external ALU, result/error back
//   rsp_*      : response channel (valid/ready, result, error, tag)
//   busy       : sequencer has queued or in-flight work
//   err_count  : saturating count of accepted error responses
// Modports: slave = the sequencer, master = its environment.
interface alu_op_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_tag;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        alu_error;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic [3:0]  rsp_tag;

    logic        busy;
    logic [7:0]  err_count;

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode,
        input  alu_result, alu_error,
        output rsp_valid, rsp_result, rsp_error, rsp_tag,
        input  rsp_ready,
        output busy, err_count
    );

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode,
        output alu_result, alu_error,
        input  rsp_valid, rsp_result, rsp_error, rsp_tag,
        output rsp_ready,
        input  busy, err_count
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Queues ALU commands in a DEPTH-entry FIFO, issues them one at a time to an
// external registered ALU with ALU_LAT cycles of latency, captures the
// result and holds it on a valid/ready response channel. Invalid opcodes
// (101..111) bypass the ALU and respond with result 0, error 1.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : alu_op_sequencer_if.slave (command, ALU, response, status)
module alu_op_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] WAIT_LAST = 3'((ALU_LAT > 1) ? (ALU_LAT - 2) : 0);
    localparam logic [2:0] OP_IDLE   = 3'b010;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    logic [2:0]  fifo_op  [DEPTH];
    logic [31:0] fifo_a   [DEPTH];
    logic [31:0] fifo_b   [DEPTH];
    logic [3:0]  fifo_tag [DEPTH];

    ptr_t        wr_ptr;
    ptr_t        rd_ptr;
    cnt_t        count;
    state_t      state;
    logic [2:0]  wait_cnt;
    logic [3:0]  cur_tag;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        head_ok;
    logic [2:0]  head_op;
    logic [31:0] head_a;
    logic [31:0] head_b;
    logic [3:0]  head_tag;

    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == cnt_t'(DEPTH));
        // No pop-through: readiness depends only on the registered occupancy.
        push       = bus.cmd_valid && !fifo_full;
        pop        = !fifo_empty &&
                     ((state == IDLE) || ((state == RESP) && bus.rsp_ready));
        head_op    = fifo_op[rd_ptr];
        head_a     = fifo_a[rd_ptr];
        head_b     = fifo_b[rd_ptr];
        head_tag   = fifo_tag[rd_ptr];
        head_ok    = (head_op <= 3'b100);
    end

    assign bus.cmd_ready = !fifo_full;
    assign bus.busy      = !fifo_empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_op[wr_ptr]  <= bus.cmd_opcode;
            fifo_a[wr_ptr]   <= bus.cmd_a;
            fifo_b[wr_ptr]   <= bus.cmd_b;
            fifo_tag[wr_ptr] <= bus.cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            wait_cnt       <= '0;
            cur_tag        <= '0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_error  <= 1'b0;
            bus.rsp_tag    <= '0;
            bus.err_count  <= '0;
            bus.alu_opcode <= OP_IDLE;
            bus.alu_a      <= '0;
            bus.alu_b      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            case ({push, pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: ;
            endcase

            case (state)
                IDLE: ;
                ISSUE: begin
                    if (ALU_LAT > 1) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end else begin
                        state          <= CAPTURE;
                        bus.alu_opcode <= OP_IDLE;
                        bus.alu_a      <= '0;
                        bus.alu_b      <= '0;
                    end
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state          <= CAPTURE;
                        bus.alu_opcode <= OP_IDLE;
                        bus.alu_a      <= '0;
                        bus.alu_b      <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                CAPTURE: begin
                    bus.rsp_result <= bus.alu_result;
                    bus.rsp_error  <= bus.alu_error;
                    bus.rsp_tag    <= cur_tag;
                    bus.rsp_valid  <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        if (bus.rsp_error && (bus.err_count != 8'hFF))
                            bus.err_count <= bus.err_count + 8'd1;
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Dispatch of the popped head is shared by IDLE and the RESP
            // handshake; these later assignments override the RESP exit above.
            if (pop) begin
                if (head_ok) begin
                    state          <= ISSUE;
                    bus.alu_opcode <= head_op;
                    bus.alu_a      <= head_a;
                    bus.alu_b      <= head_b;
                    cur_tag        <= head_tag;
                end else begin
                    state          <= RESP;
                    bus.rsp_valid  <= 1'b1;
                    bus.rsp_result <= '0;
                    bus.rsp_error  <= 1'b1;
                    bus.rsp_tag    <= head_tag;
                end
            end
        end
    end

endmodule
